fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the async_fifo write port among NUM_REQ producers in the clk_wr domain.

---
 rtl/fifo_wr_arbiter_pkg.sv | 9 +
 rtl/rr_next_sel.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin successor search: first set bit of req after ptr, wrapping; falls back to ptr.
module rr_next_sel #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   ptr,
  output logic [REQ_W-1:0]   sel,
  output logic               found
);

  int unsigned      idx;
  logic [REQ_W-1:0] cand;

  always_comb begin
    sel   = ptr;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    // Offset NUM_REQ lands back on ptr itself, so a lone requester re-selects itself.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx  = (32'(ptr) + k) % NUM_REQ;
      cand = REQ_W'(idx);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the async_fifo write port: one owner at a time, bursts capped at
// MAX_BURST beats, grants gated by full, data forwarded combinationally.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  localparam int REQ_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_wr,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     full,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     wr_en,
  output logic [WIDTH-1:0]         wdata,
  output logic [REQ_W-1:0]         owner,
  output logic                     busy,
  output logic                     stall
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [REQ_W-1:0] LAST_INIT = REQ_W'(NUM_REQ - 1);

  arb_state_e       state, state_nxt;
  logic [REQ_W-1:0] last, last_nxt, owner_nxt;
  logic [REQ_W-1:0] ptr, sel;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             found, xfer, leave;
  logic [WIDTH-1:0] slice [NUM_REQ];

  // One search serves both states: from last when idle, from the owner when handing over.
  assign ptr = (state == ST_OWN) ? owner : last;

  rr_next_sel #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_rr_next_sel (
    .req   (req),
    .ptr   (ptr),
    .sel   (sel),
    .found (found)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slice[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    gnt   = '0;
    wr_en = 1'b0;
    wdata = '0;
    busy  = 1'b0;
    stall = 1'b0;
    xfer  = 1'b0;
    if (state == ST_OWN) begin
      busy       = 1'b1;
      xfer       = req[owner] & ~full;
      stall      = req[owner] & full;
      gnt[owner] = xfer;
      wr_en      = |(req & gnt);
      wdata      = wr_en ? slice[owner] : '0;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    last_nxt     = last;
    beat_cnt_nxt = beat_cnt;
    leave        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          owner_nxt    = sel;
          beat_cnt_nxt = '0;
          state_nxt    = ST_OWN;
        end
      end
      ST_OWN: begin
        leave = ~req[owner] | (xfer & (beat_cnt == LAST_BEAT));
        if (xfer) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
        if (leave) begin
          last_nxt     = owner;
          beat_cnt_nxt = '0;
          if (found) begin
            owner_nxt = sel;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_wr) begin
    if (!rst) begin
      state    <= ST_IDLE;
      owner    <= '0;
      last     <= LAST_INIT;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// against a cycle-level behavioural model and a depth-8 FIFO environment.
module tb_fifo_wr_arbiter;

  localparam int NR    = 4;
  localparam int W     = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 8;

  logic            clk_wr = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] req_data;
  logic            full;
  logic [NR-1:0]   gnt;
  logic            wr_en;
  logic [W-1:0]    wdata;
  logic [1:0]      owner;
  logic            busy;
  logic            stall;

  always #5 clk_wr = ~clk_wr;

  fifo_wr_arbiter #(
    .WIDTH     (W),
    .NUM_REQ   (NR),
    .MAX_BURST (MB)
  ) dut (
    .clk_wr   (clk_wr),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .full     (full),
    .gnt      (gnt),
    .wr_en    (wr_en),
    .wdata    (wdata),
    .owner    (owner),
    .busy     (busy),
    .stall    (stall)
  );

  int checks   = 0;
  int failures = 0;

  // Model: whether an owner holds the port, who, who owned last, beats left in the burst.
  bit m_valid = 1'b0;
  bit m_own   = 1'b0;
  int m_owner = 0;
  int m_last  = NR - 1;
  int m_left  = 0;

  int            seq [NR];
  logic [W-1:0]  fifo_q [$];
  logic [NR-1:0] xfer_mask = '0;
  logic [NR-1:0] cur_req   = '0;

  logic          obs_we, obs_busy, obs_stall;
  logic [NR-1:0] obs_gnt;
  logic [1:0]    obs_owner;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [W-1:0] word(input int i);
    return W'((i << 6) | (seq[i] & 63));
  endfunction

  function automatic int rr(input logic [NR-1:0] r, input int p);
    for (int k = 1; k <= NR; k++) begin
      if (r[2'((p + k) % NR)]) return (p + k) % NR;
    end
    return p;
  endfunction

  // One clock cycle: drive inputs, compare outputs mid-cycle, then advance model and FIFO at the edge.
  task automatic step(input logic [NR-1:0] r, input logic rn, input logic rd);
    logic [NR-1:0] e_gnt;
    logic [W-1:0]  e_wd;
    logic          e_stall, ro;
    bit            g;
    req     = r;
    rst     = rn;
    cur_req = r;
    full    = (fifo_q.size() >= DEPTH);
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = word(i);
    #3;
    ro      = r[2'(m_owner)];
    g       = m_own && ro && !full;
    e_gnt   = g ? (NR'(1) << m_owner) : '0;
    e_wd    = g ? word(m_owner) : '0;
    e_stall = m_own && ro && full;
    obs_we    = wr_en;
    obs_busy  = busy;
    obs_stall = stall;
    obs_gnt   = gnt;
    obs_owner = owner;
    if (m_valid) begin
      check("gnt",   32'(gnt),   32'(e_gnt));
      check("wr_en", 32'(wr_en), 32'(g));
      check("wdata", 32'(wdata), 32'(e_wd));
      check("owner", 32'(owner), 32'(m_owner));
      check("busy",  32'(busy),  32'(m_own));
      check("stall", 32'(stall), 32'(e_stall));
    end
    @(posedge clk_wr);
    if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (g) begin
      fifo_q.push_back(e_wd);
      seq[m_owner]++;
    end
    xfer_mask = e_gnt & r;
    if (!rn) begin
      m_valid = 1'b1;
      m_own   = 1'b0;
      m_owner = 0;
      m_last  = NR - 1;
      m_left  = 0;
    end else if (m_valid) begin
      if (!m_own) begin
        if (r != '0) begin
          m_owner = rr(r, m_last);
          m_left  = MB;
          m_own   = 1'b1;
        end
      end else begin
        if (g) m_left--;
        if (!ro || (g && m_left == 0)) begin
          m_last = m_owner;
          if (r != '0) begin
            m_owner = rr(r, m_owner);
            m_left  = MB;
          end else begin
            m_own = 1'b0;
          end
        end
      end
    end
    #1;
  endtask

  // Requesters hold req until granted; occasionally drop without a grant.
  task automatic rand_step(input int rd_pct);
    logic [NR-1:0] r;
    logic          rn, rd;
    r = cur_req;
    for (int i = 0; i < NR; i++) begin
      if (r[i]) begin
        if (xfer_mask[i])                  r[i] = ($urandom_range(0, 3) != 0);
        else if ($urandom_range(0, 15) == 0) r[i] = 1'b0;
      end else begin
        r[i] = ($urandom_range(0, 2) == 0);
      end
    end
    rn = ($urandom_range(0, 199) != 0);
    rd = ($urandom_range(0, 99) < rd_pct);
    step(r, rn, rd);
  endtask

  initial begin
    int n, first, lastc;
    rst      = 1'b0;
    req      = '0;
    req_data = '0;
    full     = 1'b0;
    for (int i = 0; i < NR; i++) seq[i] = 16 + i;
    @(posedge clk_wr);
    #1;

    // Reset, then a single requester after the arbitration bubble
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    check("rst_gnt",   32'(obs_gnt),   32'd0);
    check("rst_wr_en", 32'(obs_we),    32'd0);
    check("rst_owner", 32'(obs_owner), 32'd0);
    check("rst_busy",  32'(obs_busy),  32'd0);
    check("rst_stall", 32'(obs_stall), 32'd0);
    step(4'b0100, 1'b1, 1'b0);
    check("s1_bubble", 32'(obs_busy), 32'd0);
    step(4'b0100, 1'b1, 1'b0);
    check("s1_owner", 32'(obs_owner), 32'd2);
    check("s1_gnt",   32'(obs_gnt),   32'b0100);
    step('0, 1'b1, 1'b0);
    repeat (10) step('0, 1'b1, 1'b1);

    // Sole requester streams past MAX_BURST with no gap
    n = 0; first = -1; lastc = -1;
    for (int c = 0; c < 20 && seq[0] < 16 + 6 + 64; c++) begin
      if (n == 6) break;
      step(4'b0001, 1'b1, 1'b0);
      if (obs_we) begin
        n++;
        if (first < 0) first = c;
        lastc = c;
      end
    end
    check("s2_beats", 32'(n), 32'd6);
    check("s2_nogap", 32'(lastc - first + 1), 32'd6);
    step('0, 1'b1, 1'b1);
    repeat (10) step('0, 1'b1, 1'b1);

    // Fill the FIFO with no reads: exactly DEPTH writes, then stall
    n = 0;
    repeat (14) begin
      step(4'b0010, 1'b1, 1'b0);
      if (obs_we) n++;
    end
    check("s4_writes", 32'(n), 32'd8);
    check("s4_stall",  32'(obs_stall), 32'd1);
    check("s4_gnt",    32'(obs_gnt),   32'd0);
    n = 0;
    step(4'b0010, 1'b1, 1'b1); if (obs_we) n++;
    step(4'b0010, 1'b1, 1'b1); if (obs_we) n++;
    step(4'b0010, 1'b1, 1'b0); if (obs_we) n++;
    step(4'b0010, 1'b1, 1'b0); if (obs_we) n++;
    check("s4_refill", 32'(n), 32'd2);
    repeat (12) step('0, 1'b1, 1'b1);

    // Reset mid-burst, then round-robin restarts from requester 0
    for (int c = 0; c < 12; c++) begin
      if (m_own && m_owner == 2 && m_left == MB - 2) break;
      step(4'b0100, 1'b1, 1'b1);
    end
    step(4'b0100, 1'b0, 1'b1);
    step(4'b0101, 1'b1, 1'b1);
    check("s6_gnt",   32'(obs_gnt),   32'd0);
    check("s6_we",    32'(obs_we),    32'd0);
    check("s6_busy",  32'(obs_busy),  32'd0);
    check("s6_owner", 32'(obs_owner), 32'd0);
    step(4'b0101, 1'b1, 1'b1);
    check("s6_first", 32'(obs_owner), 32'd0);
    check("s6_busy1", 32'(obs_busy),  32'd1);
    repeat (3) step(4'b0101, 1'b1, 1'b1);
    step(4'b0101, 1'b1, 1'b1);
    check("s6_second", 32'(obs_owner), 32'd2);
    check("s6_gnt2",   32'(obs_gnt),   32'b0100);

    // Randomized traffic with intermittent reads and occasional resets
    repeat (1500) rand_step(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
